perf_counter_bank: RTL
======================

# perf_counter_bank

Parametrised bank of event counters for the CPU datapath. It is the successor to the fixed cycle/instruction counter pair: any number of counters, configurable width, memory-mapped preload, whole-bank snapshot and sticky overflow flags. It sits beside the third pipeline stage. Reads return on the same one-cycle schedule as data-cache loads, and the read port obeys the pipeline stall.

## Interface
- NUM_CNT, 4, number of counters; legal range 1..16
- CNT_WIDTH, 32, bits per counter; legal range 8..32; reads are zero-extended to 32 bits
- CLK  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  pipeline stall; while high, rd_en and wr_en are ignored and rd_data holds
- event_inc  in  NUM_CNT  bit i high increments counter i by 1 in that cycle
- clr_all  in  1  clears all counters and overflow flags (e.g. driven from a counter-reset store)
- snap  in  1  copies all live counters into their shadow registers
- rd_en  in  1  read request
- rd_addr  in  5  bits [3:0] select the counter index; bit 4 selects the value (0 = live counter, 1 = shadow)
- rd_data  out  32  registered read data
- wr_en  in  1  preload request
- wr_addr  in  4  counter index to preload
- wr_data  in  32  preload value; bits [CNT_WIDTH-1:0] are used
- ovf  out  NUM_CNT  sticky overflow flag per counter

## Operation
- Per counter i, each cycle, evaluated in this priority order:
  1. reset or clr_all: counter = 0, ovf[i] = 0.
  2. Write accepted to i (wr_en & ~stall & wr_addr == i): counter = wr_data[CNT_WIDTH-1:0], ovf[i] = 0. The write wins over a simultaneous event_inc[i].
  3. event_inc[i]: counter = counter + 1, modulo 2^CNT_WIDTH. On the wrap from all-ones to 0, ovf[i] is set.
- Counting ignores stall. Events are counted every cycle they are asserted.
- snap copies every counter's pre-edge value into its shadow register.
  - A same-cycle write or increment does not appear in the shadow.
  - Shadows are cleared only by reset; clr_all leaves them unchanged.
- Read accepted (rd_en & ~stall):
  - rd_data is loaded with the zero-extended live or shadow value of counter rd_addr[3:0].
  - The value sampled is the pre-edge value, so a same-cycle write to that counter is not visible.
  - If the index is >= NUM_CNT, rd_data is loaded with 0.
- If no read is accepted, rd_data holds its previous value.
- A write with wr_addr >= NUM_CNT is ignored.
- ovf is a direct register output; it is never cleared by a read.

## Timing
- Reset: all counters, shadows, ovf and rd_data are 0 on the first edge with reset high. reset has priority over every other input.
- Read latency: exactly 1 cycle. A read accepted at edge N shows its data on rd_data after edge N and holds until the next accepted read. There is no handshake; a read is accepted every cycle it is requested.
- Write latency: the preloaded value is visible to a read issued in the following cycle.
- Increment latency: an event at edge N is visible to a read issued in cycle N+1.
- Stall mid-operation: a read or write presented during stall is dropped, not deferred. rd_data stays frozen for the whole stall.
- Simultaneous events on one counter: reset > clr_all > write > increment.
- Wrap with a simultaneous write: the write wins and ovf[i] = 0.
- snap during clr_all: the shadows capture the pre-clear values.

## Test plan
- Reset, then event_inc = 4'b0001 for 10 cycles, then read addr 0 → rd_data = 10 one cycle after the read; reads of addr 1..3 return 0.
- With CNT_WIDTH = 8: write 0xFE to counter 2, then 2 increments → counter = 0x00, ovf[2] = 1. Then write 0x05 → ovf[2] = 0 and a read returns 0x05.
- Counter 1 = 100. Assert snap and event_inc[1] together, then 5 more increments. Read addr 5'b10001 → 100; read addr 5'b00001 → 106.
- Assert wr_en (addr 0, data 50), event_inc[0], and a read of addr 0 in the same cycle. That read returns the old value; the next read returns 50, not 51.
- Assert stall with rd_en and wr_en (addr 3, data 7) for 3 cycles. rd_data is unchanged and counter 3 is not written, but event_inc[3] still counts 3.
- Counters at non-zero values with ovf[0] set; pulse clr_all → all counters 0 and ovf = 0, shadows keep their prior values. A read of index 9 (with NUM_CNT = 4) returns 0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: parametrised bank of event counters with preload,
// whole-bank snapshot into shadow registers, sticky overflow flags and a
// registered one-cycle read port that freezes while the pipeline stalls.
//
// Port behaviour: there is no valid/ready handshake. A read or write is
// accepted in any cycle where its enable is high and stall is low; anything
// presented during stall is dropped, never deferred. rd_data changes only
// on an accepted read and otherwise holds.
module perf_counter_bank #(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               stall,
  input  logic [NUM_CNT-1:0] event_inc,
  input  logic               clr_all,
  input  logic               snap,
  input  logic               rd_en,
  input  logic [4:0]         rd_addr,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [31:0]        wr_data,
  output logic [NUM_CNT-1:0] ovf
);

  logic [CNT_WIDTH-1:0] cnt_q    [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d    [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_d [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf_q;
  logic [NUM_CNT-1:0]   ovf_d;
  logic [31:0]          rd_data_q;
  logic [31:0]          rd_data_d;
  logic [31:0]          rd_val;
  logic                 rd_accept;
  logic                 wr_accept;

  // Only the low CNT_WIDTH bits of the preload value are stored.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  assign rd_accept = rd_en & ~stall;
  assign wr_accept = wr_en & ~stall;

  // Next counter, overflow and shadow state: clear beats write beats increment.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i]    = cnt_q[i];
      ovf_d[i]    = ovf_q[i];
      // Snapshot always takes the pre-edge live value.
      shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
      if (clr_all) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (wr_accept && (int'(wr_addr) == i)) begin
        cnt_d[i] = wr_data[CNT_WIDTH-1:0];
        ovf_d[i] = 1'b0;
      end else if (event_inc[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Read mux over pre-edge state; out-of-range indices read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(rd_addr[3:0]) == i) begin
        rd_val = rd_addr[4] ? 32'(shadow_q[i]) : 32'(cnt_q[i]);
      end
    end
    rd_data_d = rd_accept ? rd_val : rd_data_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q     <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;

endmodule
